store_narrow: RTL

- Store-side counterpart of the load/immediate widening path. Narrows a 32-bit register value to byte, halfword or word and writes it into word-organised data memory.
- Sub-word stores use a read-modify-write sequence. The block also reports misalignment and signed-narrowing overflow.
- Sits between the EX/MEM stage and the data-memory port. It stalls the pipeline via `busy` until the store completes.

---
 rtl/store_narrow_pkg.sv | 27 ++
 rtl/store_narrow_lane_merge.sv | 35 +++
 rtl/store_narrow.sv | 134 +++++++++++++
 3 files changed

// File: rtl/store_narrow_pkg.sv
// Shared encodings for the store-narrowing path: access sizes, FSM states, alignment rule.
// The load/widening path reuses the size encodings.
package store_narrow_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_ILL  = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Illegal size encodings are reported as misaligned so they never touch memory.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/store_narrow_lane_merge.sv
// Combinational byte/half/word lane merge of a store value into an old memory word,
// plus the signed-narrowing overflow flag.
module lane_merge
    import store_narrow_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_merged_word,
    output logic        o_ovf
);

    always_comb begin
        o_merged_word = i_old_word;
        o_ovf         = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_merged_word[{i_addr_lo, 3'b000} +: 8] = i_st_data[7:0];
                o_ovf = i_st_data[31:8] != {24{i_st_data[7]}};
            end
            SZ_HALF: begin
                o_merged_word[{i_addr_lo[1], 4'b0000} +: 16] = i_st_data[15:0];
                o_ovf = i_st_data[31:16] != {16{i_st_data[15]}};
            end
            SZ_WORD: begin
                o_merged_word = i_st_data;
            end
            default: begin
                o_merged_word = i_old_word;
            end
        endcase
    end

endmodule

// File: rtl/store_narrow.sv
// Narrows a register value to byte/half/word and stores it via read-modify-write when sub-word.
// Done after 1 (error), 3 (word) or 3+RD_LAT (sub-word) cycles; busy holds the pipeline meanwhile.
module store_narrow
    import store_narrow_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    input  logic [1:0]        st_size,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    output logic              busy,
    output logic              done,
    output logic              err_align,
    output logic              ovf,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata
);

    localparam logic [1:0] LP_RD_LAT = 2'(RD_LAT);

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic [31:0]       r_wdata;
    logic [1:0]        r_cnt;
    logic              r_armed;
    logic              r_err;
    logic              r_ovf;
    logic              r_mem_rd;
    logic              w_misaligned;
    logic [31:0]       w_merged;
    logic              w_ovf;

    assign w_misaligned = misaligned(st_size, st_addr[1:0]);

    lane_merge u_lane_merge (
        .i_size        (r_size),
        .i_addr_lo     (r_addr[1:0]),
        .i_old_word    (mem_rdata),
        .i_st_data     (r_data),
        .o_merged_word (w_merged),
        .o_ovf         (w_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (st_valid) begin
                    if (w_misaligned)          w_next = ST_DONE;
                    else if (st_size == SZ_WORD) w_next = ST_WRITE;
                    else                         w_next = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: if (r_cnt == 2'd0) w_next = ST_WRITE;
            ST_WRITE:   if (r_armed)       w_next = ST_DONE;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // A word store spends its first WRITE cycle presenting address/data before the strobe;
    // a sub-word store already had the address on the bus during the read, so it arrives armed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_size   <= SZ_BYTE;
            r_addr   <= '0;
            r_data   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_armed  <= 1'b0;
            r_err    <= 1'b0;
            r_ovf    <= 1'b0;
            r_mem_rd <= 1'b0;
        end else begin
            r_mem_rd <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (st_valid) begin
                        r_size   <= st_size;
                        r_addr   <= st_addr;
                        r_data   <= st_data;
                        r_wdata  <= st_data;
                        r_cnt    <= LP_RD_LAT;
                        r_armed  <= 1'b0;
                        r_err    <= w_misaligned;
                        r_ovf    <= 1'b0;
                        r_mem_rd <= !w_misaligned && (st_size != SZ_WORD);
                    end
                end
                ST_RD_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_wdata <= w_merged;
                        r_ovf   <= w_ovf;
                        r_armed <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                ST_WRITE: r_armed <= 1'b1;
                default:  r_armed <= r_armed;
            endcase
        end
    end

    always_comb begin
        busy      = r_state != ST_IDLE;
        done      = r_state == ST_DONE;
        err_align = done && r_err;
        ovf       = done && r_ovf;
        mem_rd    = r_mem_rd;
        mem_wr    = (r_state == ST_WRITE) && r_armed;
        mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
        mem_wdata = r_wdata;
    end

endmodule
